// File: rtl/conv_pkg.sv
// Shared types for the convolution window path.
package conv_pkg;

  localparam int unsigned DEF_KERNEL_SIZE         = 3;
  localparam int unsigned DEF_BITS_PER_COORDINATE = 8;
  localparam int unsigned DEF_IN_CHANNELS         = 4;
  localparam int unsigned DEF_KIDX_W              = $clog2(DEF_KERNEL_SIZE);

  // Window sequencer control states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } window_state_t;

  // Kernel tap index for the default kernel size
  typedef logic [DEF_KIDX_W-1:0] kidx_t;

  // One output beat toward the membrane-update stage (default geometry)
  typedef struct packed {
    logic [DEF_BITS_PER_COORDINATE-1:0] x;
    logic [DEF_BITS_PER_COORDINATE-1:0] y;
    kidx_t                              kx;
    kidx_t                              ky;
    logic [DEF_IN_CHANNELS-1:0]         spikes;
  } win_beat_t;

endpackage

// File: rtl/conv_window_clip.sv
// Signed output-position offset for one kernel tap plus image bounds check.
module conv_window_clip #(
  parameter int unsigned IMG_WIDTH           = 32,
  parameter int unsigned IMG_HEIGHT          = 32,
  parameter int unsigned BITS_PER_COORDINATE = 8,
  parameter int unsigned KERNEL_SIZE         = 3
) (
  input  logic [BITS_PER_COORDINATE-1:0]        x,
  input  logic [BITS_PER_COORDINATE-1:0]        y,
  input  logic [$clog2(KERNEL_SIZE)-1:0]        kx,
  input  logic [$clog2(KERNEL_SIZE)-1:0]        ky,
  output logic signed [BITS_PER_COORDINATE+1:0] ox,
  output logic signed [BITS_PER_COORDINATE+1:0] oy,
  output logic                                  in_bounds
);

  localparam int unsigned CW = BITS_PER_COORDINATE + 2;
  localparam int unsigned P  = (KERNEL_SIZE - 1) / 2;

  localparam logic signed [CW-1:0] P_S   = CW'(P);
  localparam logic signed [CW-1:0] W_LIM = CW'(IMG_WIDTH);
  localparam logic signed [CW-1:0] H_LIM = CW'(IMG_HEIGHT);

  logic signed [CW-1:0] xs, ys, kxs, kys;

  // Zero-extend coordinates and taps into the signed working width
  assign xs  = CW'(x);
  assign ys  = CW'(y);
  assign kxs = CW'(kx);
  assign kys = CW'(ky);

  // Candidate output neuron: o = in + P - k
  always_comb begin
    ox        = xs + P_S - kxs;
    oy        = ys + P_S - kys;
    in_bounds = !ox[CW-1] && (ox < W_LIM) && !oy[CW-1] && (oy < H_LIM);
  end

endmodule

// File: rtl/conv_window_sequencer.sv
// Walks the kernel neighbourhood of one input event and emits in-bounds output beats.
module conv_window_sequencer
  import conv_pkg::*;
#(
  parameter int unsigned IMG_WIDTH           = 32,
  parameter int unsigned IMG_HEIGHT          = 32,
  parameter int unsigned BITS_PER_COORDINATE = 8,
  parameter int unsigned IN_CHANNELS         = 4,
  parameter int unsigned KERNEL_SIZE         = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             event_valid,
  input  logic [BITS_PER_COORDINATE-1:0]   event_x,
  input  logic [BITS_PER_COORDINATE-1:0]   event_y,
  input  logic [IN_CHANNELS-1:0]           event_spikes,
  output logic                             conv_ack,
  output logic                             win_valid,
  input  logic                             win_ready,
  output logic [BITS_PER_COORDINATE-1:0]   win_x,
  output logic [BITS_PER_COORDINATE-1:0]   win_y,
  output logic [$clog2(KERNEL_SIZE)-1:0]   win_kx,
  output logic [$clog2(KERNEL_SIZE)-1:0]   win_ky,
  output logic [IN_CHANNELS-1:0]           win_spikes
);

  localparam int unsigned KW = $clog2(KERNEL_SIZE);
  localparam int unsigned BW = BITS_PER_COORDINATE;
  localparam int unsigned CW = BITS_PER_COORDINATE + 2;
  localparam logic [KW-1:0] KMAX = KW'(KERNEL_SIZE - 1);

  window_state_t          state_q, state_n;
  logic [KW-1:0]          kx_q, kx_n, ky_q, ky_n;
  logic [BW-1:0]          ev_x_q, ev_x_n, ev_y_q, ev_y_n;
  logic [IN_CHANNELS-1:0] ev_spk_q, ev_spk_n;

  logic signed [CW-1:0]   ox, oy;
  logic                   in_bounds;
  logic                   advance;
  logic                   unused_hi;

  conv_window_clip #(
    .IMG_WIDTH          (IMG_WIDTH),
    .IMG_HEIGHT         (IMG_HEIGHT),
    .BITS_PER_COORDINATE(BITS_PER_COORDINATE),
    .KERNEL_SIZE        (KERNEL_SIZE)
  ) u_clip (
    .x        (ev_x_q),
    .y        (ev_y_q),
    .kx       (kx_q),
    .ky       (ky_q),
    .ox       (ox),
    .oy       (oy),
    .in_bounds(in_bounds)
  );

  // Sign/overflow bits only matter inside the bounds check
  assign unused_hi = ^{ox[CW-1:BW], oy[CW-1:BW]};

  // Beat presentation straight from the registered walk state
  assign win_valid  = (state_q == SCAN) && in_bounds;
  assign win_x      = ox[BW-1:0];
  assign win_y      = oy[BW-1:0];
  assign win_kx     = kx_q;
  assign win_ky     = ky_q;
  assign win_spikes = ev_spk_q;

  // Clipped taps step without a handshake; live taps wait for the consumer
  assign advance = !in_bounds || win_ready;

  // State, counters, event capture and ack pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      kx_q     <= '0;
      ky_q     <= '0;
      ev_x_q   <= '0;
      ev_y_q   <= '0;
      ev_spk_q <= '0;
      conv_ack <= 1'b0;
    end else begin
      state_q  <= state_n;
      kx_q     <= kx_n;
      ky_q     <= ky_n;
      ev_x_q   <= ev_x_n;
      ev_y_q   <= ev_y_n;
      ev_spk_q <= ev_spk_n;
      conv_ack <= (state_n == DONE);
    end
  end

  // Next-state, raster counter walk and event load
  always_comb begin
    state_n  = state_q;
    kx_n     = kx_q;
    ky_n     = ky_q;
    ev_x_n   = ev_x_q;
    ev_y_n   = ev_y_q;
    ev_spk_n = ev_spk_q;

    unique case (state_q)
      IDLE: begin
        if (event_valid) begin
          ev_x_n   = event_x;
          ev_y_n   = event_y;
          ev_spk_n = event_spikes;
          kx_n     = '0;
          ky_n     = '0;
          state_n  = (event_spikes == '0) ? DONE : SCAN;
        end
      end
      SCAN: begin
        if (advance) begin
          if (kx_q == KMAX) begin
            kx_n = '0;
            if (ky_q == KMAX) begin
              ky_n    = '0;
              state_n = DONE;
            end else begin
              ky_n = ky_q + KW'(1);
            end
          end else begin
            kx_n = kx_q + KW'(1);
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: doc/conv_window_sequencer.md
# conv_window_sequencer

Downstream neighbour of the event capture stage in the convolution path. Accepts one validated input event (x, y, per-channel spikes) at a time. Walks the KERNEL_SIZE x KERNEL_SIZE neighbourhood of output neurons the event touches (stride 1, same padding) and emits one beat per in-bounds output position to the membrane-update stage under valid/ready. When the walk is complete, it pulses conv_ack back to the capture stage.

## Interface
Parameters:
- IMG_WIDTH, 32, output map width (equal to the input width, same padding)
- IMG_HEIGHT, 32, output map height
- BITS_PER_COORDINATE, 8, width of x/y fields
- IN_CHANNELS, 4, spike vector width
- KERNEL_SIZE, 3, odd kernel edge length; P = (KERNEL_SIZE-1)/2

Ports:
- clk  in  1  single clock; everything is posedge
- rst  in  1  synchronous, active-high reset
- event_valid  in  1  capture stage presents an event
- event_x  in  BITS_PER_COORDINATE  event column
- event_y  in  BITS_PER_COORDINATE  event row
- event_spikes  in  IN_CHANNELS  channel spike mask
- conv_ack  out  1  one-cycle pulse: event fully consumed
- win_valid  out  1  output beat valid
- win_ready  in  1  downstream accepts beat
- win_x, win_y  out  BITS_PER_COORDINATE  target output neuron
- win_kx, win_ky  out  $clog2(KERNEL_SIZE)  kernel tap index
- win_spikes  out  IN_CHANNELS  registered copy of event_spikes

## Operation
- States:
  - IDLE: sample the event on event_valid; if spikes are zero, go to DONE; otherwise clear the counters and go to SCAN.
  - SCAN: walk the kernel positions (see candidate rules below); after the final tap, go to DONE.
  - DONE: conv_ack=1 for exactly one cycle, then IDLE.
- event_x/y/spikes are registered on acceptance. Inputs are ignored outside IDLE.
- Counters ky (outer) and kx (inner) run from 0 to KERNEL_SIZE-1 in raster order.
- Candidate per (kx, ky):
  - ox = x + P − kx and oy = y + P − ky, computed signed in BITS_PER_COORDINATE+2 bits.
  - In bounds iff 0 ≤ ox < IMG_WIDTH and 0 ≤ oy < IMG_HEIGHT.
- An in-bounds candidate drives win_valid=1. The counters advance only on win_valid && win_ready.
- An out-of-bounds candidate drives win_valid=0, and the counters advance unconditionally that cycle.
- win_* outputs are combinational from the registered counters and the event register. They are stable while win_valid && !win_ready.
- Input coordinates beyond the image are not rejected; clipping naturally suppresses beats.
- A timestep marker never reaches this block; capture filters it.

## Timing
- Reset values: state=IDLE, conv_ack=0, win_valid=0, counters=0, event register=0.
- Event accepted at edge E (cycle 0):
  - SCAN occupies cycles 1..KERNEL_SIZE² with win_ready=1.
  - conv_ack fires in cycle KERNEL_SIZE²+1.
  - IDLE returns the next cycle.
- Each cycle of backpressure on an in-bounds beat adds one cycle of latency.
- Zero-spike event: DONE in cycle 1, no beats.
- event_valid held high through DONE and still high in the following IDLE is accepted as a new event. The capture stage guarantees it drops valid on seeing conv_ack, so no double capture occurs.
- rst asserted in any state: the next cycle is IDLE with all outputs at reset values. The in-flight event is discarded and no ack is issued.
- Throughput: at most one beat per cycle; one event per KERNEL_SIZE²+2 cycles minimum.

## Structure
- conv_pkg adds:
  - window_state_t (IDLE, SCAN, DONE)
  - a kernel-index typedef sized $clog2(KERNEL_SIZE)
- Sub-module conv_window_clip: combinational signed offset plus bounds check, returning ox, oy and in_bounds. It is reused by later strided variants.

## Test plan
(KERNEL_SIZE=3, IMG 32x32, win_ready=1 unless stated)
- Interior event x=10, y=5, spikes=4'b0101:
  - 9 beats in order (11,6),(10,6),(9,6),(11,5),(10,5),(9,5),(11,4),(10,4),(9,4) with kx/ky 0..2 each.
  - win_spikes=4'b0101 on every beat.
  - conv_ack in cycle 10 only.
- Corner x=0, y=0: 4 beats (1,1),(0,1),(1,0),(0,0) from taps (0,0),(1,0),(0,1),(1,1); conv_ack still in cycle 10.
- Corner x=31, y=31: 4 beats (31,31),(30,31),(31,30),(30,30) from taps kx, ky ∈ {1,2}; conv_ack in cycle 10.
- Backpressure: interior event with win_ready low for 3 cycles on the 2nd beat. Beat (10,6) is held stable for those cycles, no beat is lost, and conv_ack moves to cycle 13.
- spikes=0 at x=4, y=4: win_valid never asserts; conv_ack in cycle 1.
- rst pulsed in SCAN cycle 4: the following cycle has win_valid=0 and state IDLE, and conv_ack never fires. A new event after reset produces a full, correct 9-beat sequence.
